ballot_collector: RTL and testbench

//   Upstream intake stage for the jury tally/display path. Accepts one ballot per juror

---
 rtl/ballot_pkg.sv | 22 ++
 rtl/ballot_check.sv | 39 +++
 rtl/ballot_collector.sv | 166 ++++++++++++++++
 tb/tb_ballot_collector.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ballot_pkg.sv
// Shared encodings for the ballot collector: choice codes, FSM states and reject causes.
package ballot_pkg;

  localparam logic [1:0] CH_A    = 2'b00;
  localparam logic [1:0] CH_B    = 2'b01;
  localparam logic [1:0] CH_C    = 2'b10;
  localparam logic [1:0] CH_ABST = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_CLOSED  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RC_NONE   = 2'd0,
    RC_RANGE  = 2'd1,
    RC_DUP    = 2'd2,
    RC_CHOICE = 2'd3
  } reject_cause_e;

endpackage

// File: rtl/ballot_check.sv
// Combinational ballot legality check: juror range, duplicate vote, and choice legality.
// Choice 11 is legal only when ABSTAIN_EN is defined.
module ballot_check
  import ballot_pkg::*;
#(
  parameter int unsigned N_JURORS = 4,
  parameter int unsigned JW       = 2
) (
  input  logic [JW-1:0]       juror_id,
  input  logic [1:0]          choice,
  input  logic [N_JURORS-1:0] mask,
  output logic                accept,
  output reject_cause_e       reject_cause
);

  logic already;

  always_comb begin
    // Loop lookup avoids indexing the mask with an out-of-range juror_id.
    already = 1'b0;
    for (int unsigned i = 0; i < N_JURORS; i++) begin
      if (juror_id == JW'(i)) already = mask[i];
    end

    reject_cause = RC_NONE;
    if ({1'b0, juror_id} >= (JW+1)'(N_JURORS)) begin
      reject_cause = RC_RANGE;
    end else if (already) begin
      reject_cause = RC_DUP;
    end
`ifndef ABSTAIN_EN
    else if (choice == CH_ABST) begin
      reject_cause = RC_CHOICE;
    end
`endif
    accept = (reject_cause == RC_NONE);
  end

endmodule

// File: rtl/ballot_collector.sv
// Jury ballot intake: valid/ready collection, duplicate/illegal rejection, per-option counts
// frozen on close. Optional feature macro: ABSTAIN_EN (accept choice 11, adds count_abstain).
module ballot_collector
  import ballot_pkg::*;
#(
  parameter int unsigned N_JURORS = 4,
  parameter int unsigned CW       = 3,
  parameter int unsigned JW       = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          open_i,
  input  logic          close_i,
  input  logic          vote_valid,
  output logic          vote_ready,
  input  logic [JW-1:0] juror_id,
  input  logic [1:0]    choice,
  output logic [CW-1:0] count_a,
  output logic [CW-1:0] count_b,
  output logic [CW-1:0] count_c,
  output logic [CW-1:0] votes_cast,
`ifdef ABSTAIN_EN
  output logic [CW-1:0] count_abstain,
`endif
  output logic          reject,
  output logic          done,
  output logic          results_valid
);

  state_e              state_q, state_d;
  logic [N_JURORS-1:0] mask_q, mask_d, sel_onehot;
  logic [CW-1:0]       count_a_q, count_a_d;
  logic [CW-1:0]       count_b_q, count_b_d;
  logic [CW-1:0]       count_c_q, count_c_d;
  logic [CW-1:0]       votes_q, votes_d;
`ifdef ABSTAIN_EN
  logic [CW-1:0]       count_abst_q, count_abst_d;
`endif
  logic                reject_q, reject_d;
  logic                done_q, done_d;
  logic                vote_ready_q, vote_ready_d;
  logic                results_valid_q, results_valid_d;

  logic                accept;
  reject_cause_e       reject_cause;

  ballot_check #(
    .N_JURORS (N_JURORS),
    .JW       (JW)
  ) u_check (
    .juror_id     (juror_id),
    .choice       (choice),
    .mask         (mask_q),
    .accept       (accept),
    .reject_cause (reject_cause)
  );

  always_comb begin
    sel_onehot = '0;
    for (int unsigned i = 0; i < N_JURORS; i++) begin
      sel_onehot[i] = (juror_id == JW'(i));
    end
  end

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    count_a_d    = count_a_q;
    count_b_d    = count_b_q;
    count_c_d    = count_c_q;
    votes_d      = votes_q;
`ifdef ABSTAIN_EN
    count_abst_d = count_abst_q;
`endif
    reject_d     = 1'b0;
    done_d       = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_CLOSED: begin
        if (open_i) begin
          state_d      = ST_COLLECT;
          mask_d       = '0;
          count_a_d    = '0;
          count_b_d    = '0;
          count_c_d    = '0;
          votes_d      = '0;
`ifdef ABSTAIN_EN
          count_abst_d = '0;
`endif
        end
      end
      ST_COLLECT: begin
        if (vote_valid) begin
          if (accept) begin
            mask_d  = mask_q | sel_onehot;
            votes_d = votes_q + CW'(1);
            unique case (choice)
              CH_A:    count_a_d = count_a_q + CW'(1);
              CH_B:    count_b_d = count_b_q + CW'(1);
              CH_C:    count_c_d = count_c_q + CW'(1);
`ifdef ABSTAIN_EN
              CH_ABST: count_abst_d = count_abst_q + CW'(1);
`endif
              default: ;
            endcase
          end
          reject_d = (reject_cause != RC_NONE);
        end
        // Close on the post-ballot tally so a final ballot and close_i coincide cleanly.
        if (close_i || votes_d == CW'(N_JURORS)) begin
          state_d = ST_CLOSED;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    vote_ready_d    = (state_d == ST_COLLECT);
    results_valid_d = (state_d == ST_CLOSED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      mask_q          <= '0;
      count_a_q       <= '0;
      count_b_q       <= '0;
      count_c_q       <= '0;
      votes_q         <= '0;
`ifdef ABSTAIN_EN
      count_abst_q    <= '0;
`endif
      reject_q        <= 1'b0;
      done_q          <= 1'b0;
      vote_ready_q    <= 1'b0;
      results_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      mask_q          <= mask_d;
      count_a_q       <= count_a_d;
      count_b_q       <= count_b_d;
      count_c_q       <= count_c_d;
      votes_q         <= votes_d;
`ifdef ABSTAIN_EN
      count_abst_q    <= count_abst_d;
`endif
      reject_q        <= reject_d;
      done_q          <= done_d;
      vote_ready_q    <= vote_ready_d;
      results_valid_q <= results_valid_d;
    end
  end

  assign vote_ready    = vote_ready_q;
  assign count_a       = count_a_q;
  assign count_b       = count_b_q;
  assign count_c       = count_c_q;
  assign votes_cast    = votes_q;
`ifdef ABSTAIN_EN
  assign count_abstain = count_abst_q;
`endif
  assign reject        = reject_q;
  assign done          = done_q;
  assign results_valid = results_valid_q;

endmodule

// File: tb/tb_ballot_collector.sv
// Directed self-checking bench for ballot_collector (default build, N_JURORS=4, JW=3 so
// juror ids 4..7 exercise the out-of-range path).
module tb_ballot_collector;

  localparam int unsigned N_JURORS = 4;
  localparam int unsigned CW       = 3;
  localparam int unsigned JW       = 3;

  logic          clk = 1'b0;
  logic          rst, open_i, close_i, vote_valid;
  logic [JW-1:0] juror_id;
  logic [1:0]    choice;
  logic          vote_ready, reject, done, results_valid;
  logic [CW-1:0] count_a, count_b, count_c, votes_cast;
`ifdef ABSTAIN_EN
  logic [CW-1:0] count_abstain;
`endif

  int vectors = 0;
  int errors  = 0;

  ballot_collector #(
    .N_JURORS (N_JURORS),
    .CW       (CW),
    .JW       (JW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .open_i        (open_i),
    .close_i       (close_i),
    .vote_valid    (vote_valid),
    .vote_ready    (vote_ready),
    .juror_id      (juror_id),
    .choice        (choice),
    .count_a       (count_a),
    .count_b       (count_b),
    .count_c       (count_c),
    .votes_cast    (votes_cast),
`ifdef ABSTAIN_EN
    .count_abstain (count_abstain),
`endif
    .reject        (reject),
    .done          (done),
    .results_valid (results_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cast(input int j, input logic [1:0] c);
    vote_valid = 1'b1;
    juror_id   = JW'(j);
    choice     = c;
    tick();
    vote_valid = 1'b0;
  endtask

  task automatic check_counts(input string tag, input int a, input int b, input int c,
                              input int v);
    check({tag, ".a"}, 8'(count_a), 8'(a));
    check({tag, ".b"}, 8'(count_b), 8'(b));
    check({tag, ".c"}, 8'(count_c), 8'(c));
    check({tag, ".votes"}, 8'(votes_cast), 8'(v));
  endtask

  initial begin
    rst = 1'b1; open_i = 1'b0; close_i = 1'b0; vote_valid = 1'b0;
    juror_id = '0; choice = 2'b00;
    tick(); tick();
    rst = 1'b0;
    check_counts("reset", 0, 0, 0, 0);
    check("reset.ready", 8'(vote_ready), 8'd0);
    check("reset.rv", 8'(results_valid), 8'd0);
    check("reset.done", 8'(done), 8'd0);
    check("reset.reject", 8'(reject), 8'd0);

    // close_i and vote_valid in IDLE are ignored
    close_i = 1'b1; tick(); close_i = 1'b0;
    check("idle_close.done", 8'(done), 8'd0);
    cast(0, 2'b00);
    check("idle_vote.reject", 8'(reject), 8'd0);
    check("idle_vote.a", 8'(count_a), 8'd0);

    // Test 1: full round of four ballots
    open_i = 1'b1; tick(); open_i = 1'b0;
    check("t1.ready", 8'(vote_ready), 8'd1);
    cast(0, 2'b00);
    check("t1.j0.reject", 8'(reject), 8'd0);
    check_counts("t1.j0", 1, 0, 0, 1);
    cast(1, 2'b01);
    cast(2, 2'b00);
    check("t1.j2.done", 8'(done), 8'd0);
    cast(3, 2'b10);
    check_counts("t1.final", 2, 1, 1, 4);
    check("t1.done", 8'(done), 8'd1);
    check("t1.rv", 8'(results_valid), 8'd1);
    check("t1.ready_off", 8'(vote_ready), 8'd0);
    tick();
    check("t1.done_pulse", 8'(done), 8'd0);
    check("t1.rv_hold", 8'(results_valid), 8'd1);
    cast(0, 2'b01);
    check("t1.closed_vote.reject", 8'(reject), 8'd0);
    check("t1.closed_vote.b", 8'(count_b), 8'd1);

    // Test 5: reopen from CLOSED clears counts, j0 may vote again
    open_i = 1'b1; tick(); open_i = 1'b0;
    check_counts("t5.clear", 0, 0, 0, 0);
    check("t5.rv", 8'(results_valid), 8'd0);
    check("t5.ready", 8'(vote_ready), 8'd1);
    cast(0, 2'b00);
    check("t5.j0.reject", 8'(reject), 8'd0);
    check("t5.j0.a", 8'(count_a), 8'd1);

    // Test 2: duplicate ballot from j1
    cast(1, 2'b00);
    check("t2.first.reject", 8'(reject), 8'd0);
    cast(1, 2'b01);
    check("t2.dup.reject", 8'(reject), 8'd1);
    check_counts("t2.dup", 2, 0, 0, 2);
    tick();
    check("t2.reject_pulse", 8'(reject), 8'd0);

    // Test 3: out-of-range juror and illegal choice
    cast(5, 2'b00);
    check("t3.range.reject", 8'(reject), 8'd1);
    check_counts("t3.range", 2, 0, 0, 2);
    cast(2, 2'b11);
    check("t3.choice.reject", 8'(reject), 8'd1);
    check_counts("t3.choice", 2, 0, 0, 2);

    // open_i mid-round ignored; then force close
    open_i = 1'b1; tick(); open_i = 1'b0;
    check("open_in_collect.a", 8'(count_a), 8'd2);
    check("open_in_collect.ready", 8'(vote_ready), 8'd1);
    close_i = 1'b1; tick(); close_i = 1'b0;
    check("force_close.done", 8'(done), 8'd1);
    check("force_close.votes", 8'(votes_cast), 8'd2);
    check("force_close.rv", 8'(results_valid), 8'd1);

    // Test 4: close_i together with the 2nd ballot
    open_i = 1'b1; tick(); open_i = 1'b0;
    cast(0, 2'b00);
    close_i = 1'b1;
    cast(1, 2'b10);
    close_i = 1'b0;
    check_counts("t4.final", 1, 0, 1, 2);
    check("t4.done", 8'(done), 8'd1);
    check("t4.ready", 8'(vote_ready), 8'd0);
    tick();
    check("t4.done_pulse", 8'(done), 8'd0);
    check("t4.ready_after", 8'(vote_ready), 8'd0);

    // Test 6: reset mid-COLLECT
    open_i = 1'b1; tick(); open_i = 1'b0;
    cast(0, 2'b00);
    cast(1, 2'b01);
    check_counts("t6.pre", 1, 1, 0, 2);
    rst = 1'b1; tick(); rst = 1'b0;
    check_counts("t6.rst", 0, 0, 0, 0);
    check("t6.ready", 8'(vote_ready), 8'd0);
    check("t6.rv", 8'(results_valid), 8'd0);
    cast(2, 2'b00);
    check("t6.ignored.reject", 8'(reject), 8'd0);
    check("t6.ignored.a", 8'(count_a), 8'd0);
    open_i = 1'b1; tick(); open_i = 1'b0;
    cast(0, 2'b10);
    check("t6.reopen.reject", 8'(reject), 8'd0);
    check_counts("t6.reopen", 0, 0, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
